// File: rtl/led_strip_driver.sv
// rtl/led_strip_driver.sv - WS2812-class serializer for a latched GRB frame
// Optional LED_AUTO_REFRESH_EN: frames repeat continuously and the start input is ignored.
module led_strip_driver #(
    parameter int NUM_LEDS = 5,
    parameter int T0H      = 20,
    parameter int T1H      = 40,
    parameter int TBIT     = 63,
    parameter int TRST     = 2500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [24*NUM_LEDS-1:0]  GRBSeq,
    input  logic                    start,
    output logic                    dout,
    output logic                    busy,
    output logic                    done
);

    localparam int N    = 24 * NUM_LEDS;
    localparam int CMAX = (TBIT > TRST) ? TBIT : TRST;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] H0_END = CW'(T0H - 1);
    localparam logic [CW-1:0] H1_END = CW'(T1H - 1);
    localparam logic [CW-1:0] L0_END = CW'(TBIT - T0H - 1);
    localparam logic [CW-1:0] L1_END = CW'(TBIT - T1H - 1);
    localparam logic [CW-1:0] R_END  = CW'(TRST - 1);
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HIGH  = 2'd1;
    localparam logic [1:0] S_LOW   = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [N-1:0]  shreg;
    logic          fin;
    logic          start_eff;
    logic          cur_bit;

`ifdef LED_AUTO_REFRESH_EN
    logic unused_start;
    assign unused_start = start;
    assign start_eff    = 1'b1;
`else
    assign start_eff    = start;
`endif

    assign cur_bit = shreg[N-1];

    // Outputs are registered images of the state, so the line follows the state by one cycle
    // and a new start is only accepted once the registered busy has fallen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            fin   <= 1'b0;
            dout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            dout <= (state == S_HIGH);
            busy <= (state != S_IDLE);
            done <= fin;
            fin  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_eff && !busy) begin
                        shreg <= GRBSeq;
                        idx   <= IDX_TOP;
                        cnt   <= '0;
                        state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (cnt == (cur_bit ? H1_END : H0_END)) begin
                        cnt   <= '0;
                        state <= S_LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LOW: begin
                    if (cnt == (cur_bit ? L1_END : L0_END)) begin
                        cnt <= '0;
                        if (idx != '0) begin
                            idx   <= idx - 1'b1;
                            shreg <= shreg << 1;
                            state <= S_HIGH;
                        end else begin
                            state <= S_LATCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (cnt == R_END) begin
                        cnt   <= '0;
                        fin   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_strip_driver.sv
// tb/tb_led_strip_driver.sv - self-checking bench for led_strip_driver
// Waveforms are compared against a bit-timing model derived from the frame data.
module tb_led_strip_driver;

    localparam int NL    = 5;
    localparam int TB0H  = 2;
    localparam int TB1H  = 4;
    localparam int TBB   = 6;
    localparam int TBR   = 10;
    localparam int NB    = 24 * NL;
    localparam int FRAME = NB * TBB + TBR;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] grb = '0;
    logic          start = 1'b0;
    logic          dout;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    led_strip_driver #(
        .NUM_LEDS(NL), .T0H(TB0H), .T1H(TB1H), .TBIT(TBB), .TRST(TBR)
    ) dut (
        .clk(clk), .reset(reset), .GRBSeq(grb), .start(start),
        .dout(dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] data;
        int            chg_at;
        logic [NB-1:0] chg_val;
        int            start2_at;
        int            exp_done_edge;
        int            exp_busy_cycles;
    } vec_t;

    // Expected line level during the cycle after edge j of a frame whose start was sampled at edge 0.
    function automatic logic m_dout(input logic [NB-1:0] d, input int j);
        int b, p;
        logic [NB-1:0] dd;
        if (j < 1 || j > NB * TBB) return 1'b0;
        b  = (j - 1) / TBB;
        p  = (j - 1) % TBB;
        dd = d;
        return (p < (dd[NB-1-b] ? TB1H : TB0H));
    endfunction

    function automatic logic m_busy(input int j);
        return (j >= 1 && j <= FRAME);
    endfunction

    function automatic logic m_done(input int j);
        return (j == FRAME + 1);
    endfunction

    function automatic logic [NB-1:0] rand_vec();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[NB-1:0];
    endfunction

    task automatic chk(input string name, input int j, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, j, act, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input int j, input logic ed, input logic eb, input logic edn);
        chk({tag, ".dout"}, j, int'(dout), int'(ed));
        chk({tag, ".busy"}, j, int'(busy), int'(eb));
        chk({tag, ".done"}, j, int'(done), int'(edn));
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int busy_cnt, done_edge, done_cnt;
        busy_cnt  = 0;
        done_edge = -1;
        done_cnt  = 0;
        @(negedge clk);
        grb   = v.data;
        start = 1'b1;
        @(posedge clk);
        #1 start = (v.start2_at == 1);
        for (int j = 1; j <= FRAME + 10; j++) begin
            @(posedge clk);
            #1;
            if (j == v.chg_at) grb = v.chg_val;
            start = (j + 1 == v.start2_at);
            @(negedge clk);
            chk_cycle(tag, j, m_dout(v.data, j), m_busy(j), m_done(j));
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_edge = j;
            end
        end
        chk({tag, ".busy_cycles"}, 0, busy_cnt, v.exp_busy_cycles);
        chk({tag, ".done_edge"}, 0, done_edge, v.exp_done_edge);
        chk({tag, ".done_count"}, 0, done_cnt, 1);
    endtask

    vec_t tbl[4];
    vec_t v;

    initial begin
        tbl[0] = '{120'h800000_000000_000000_000000_000001, -1, '0, -1, 731, 730};
        tbl[1] = '{120'h800000_000000_000000_000000_000001, 50, {NB{1'b1}}, -1, 731, 730};
        tbl[2] = '{120'h800000_000000_000000_000000_000001, -1, '0, 100, 731, 730};
        tbl[3] = '{120'hA5C33C_0F00FF_123456_FEDCBA_5A5A5A, 50, '0, 100, 731, 730};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cycle("reset", 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_cycle("idle", 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a frame, then a clean frame afterwards.
        v = tbl[3];
        @(negedge clk);
        grb   = v.data;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 1; j < 300; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk_cycle("prerst", j, m_dout(v.data, j), m_busy(j), m_done(j));
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_cycle("midrst", 300, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cycle("inrst", 302, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_cycle("postrst", 0, 1'b0, 1'b0, 1'b0);
        run_frame(tbl[0], "afterrst");

        // start held high: frames at edges 0 and 732, GRBSeq changed mid first frame.
        v = tbl[3];
        v.chg_val = rand_vec();
        @(negedge clk);
        grb   = v.data;
        start = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 1470; j++) begin
            @(posedge clk);
            #1;
            if (j == 400) grb = v.chg_val;
            if (j == 1463) start = 1'b0;
            @(negedge clk);
            if (j <= FRAME + 1)
                chk_cycle("held", j, m_dout(v.data, j), m_busy(j), m_done(j));
            else
                chk_cycle("held", j, m_dout(v.chg_val, j - 732), m_busy(j - 732), m_done(j - 732));
        end

        for (int i = 0; i < 6; i++) begin
            v.data            = rand_vec();
            v.chg_at          = int'($urandom_range(1, 700));
            v.chg_val         = rand_vec();
            v.start2_at       = int'($urandom_range(2, 720));
            v.exp_done_edge   = 731;
            v.exp_busy_cycles = 730;
            run_frame(v, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
